// File: rtl/ibex_pkg.sv
// Shared types for the IF/ID skid register: the stored fetch entry, the
// occupancy state encoding, and the fall-through PC increments.
package ibex_pkg;

  // One captured fetch result; compressed is decided at capture time.
  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
    logic        err_plus2;
    logic        compressed;
  } fetch_entry_t;

  // Occupancy of the two-entry buffer (main entry, then skid entry).
  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_ONE   = 2'd1,
    IFID_TWO   = 2'd2
  } if_id_state_e;

  // Fall-through PC increments for compressed and full-width instructions.
  localparam logic [31:0] IFID_PC_INC_COMP = 32'd2;
  localparam logic [31:0] IFID_PC_INC_FULL = 32'd4;

endpackage

// File: rtl/ibex_if_id_skid_reg_monitor.sv
// Passive companion for the IF/ID skid register: same ports, all inputs,
// carrying protocol properties that hold for any legal stimulus.
module ibex_if_id_skid_reg_monitor (
  input logic        clk_i,
  input logic        rst_ni,
  input logic        fetch_valid_i,
  input logic [31:0] fetch_rdata_i,
  input logic [31:0] fetch_addr_i,
  input logic        fetch_err_i,
  input logic        fetch_err_plus2_i,
  input logic        fetch_ready_o,
  input logic        flush_i,
  input logic        id_ready_i,
  input logic        instr_valid_id_o,
  input logic [31:0] instr_rdata_id_o,
  input logic        instr_is_compressed_id_o,
  input logic [31:0] pc_id_o,
  input logic [31:0] pc_next_id_o,
  input logic        instr_fetch_err_id_o,
  input logic        instr_fetch_err_plus2_id_o
);

  // Ready is only withheld when both entries are occupied.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !fetch_ready_o |-> instr_valid_id_o);

  // The stored compressed flag matches the held word and error.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_valid_id_o |-> (instr_is_compressed_id_o ==
      ((instr_rdata_id_o[1:0] != 2'b11) && !instr_fetch_err_id_o)));

  // Fall-through PC tracks the held PC and instruction size.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_valid_id_o |-> (pc_next_id_o ==
      (pc_id_o + (instr_is_compressed_id_o ? 32'd2 : 32'd4))));

  // A flush empties the buffer on the next cycle.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_i |=> !instr_valid_id_o);

  // The presented instruction stays put while ID stalls.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_valid_id_o && !id_ready_i && !flush_i) |=>
      (!instr_valid_id_o ||
       ($stable(pc_id_o) && $stable(instr_rdata_id_o) &&
        $stable(instr_fetch_err_id_o) && $stable(instr_fetch_err_plus2_id_o))));

  // An accept into an empty buffer appears unchanged one cycle later.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!instr_valid_id_o && fetch_valid_i && fetch_ready_o && !flush_i) |=>
      (instr_valid_id_o && pc_id_o == $past(fetch_addr_i) &&
       instr_rdata_id_o == $past(fetch_rdata_i) &&
       instr_fetch_err_id_o == $past(fetch_err_i) &&
       instr_fetch_err_plus2_id_o == $past(fetch_err_plus2_i)));

endmodule

// File: rtl/ibex_if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer. The main entry
// feeds the ID stage; the skid entry absorbs the one instruction that can
// arrive while ID stalls, so fetch_ready_o can come straight from a flop.
module ibex_if_id_skid_reg
  import ibex_pkg::*;
#(
  parameter bit ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  input  logic        fetch_err_plus2_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic        instr_is_compressed_id_o,
  output logic [31:0] pc_id_o,
  output logic [31:0] pc_next_id_o,
  output logic        instr_fetch_err_id_o,
  output logic        instr_fetch_err_plus2_id_o
);

  if_id_state_e state_q, state_d;
  logic         fetch_ready_q, fetch_ready_d;
  fetch_entry_t main_q, main_d;
  fetch_entry_t skid_q, skid_d;
  fetch_entry_t in_entry;
  logic         main_we, skid_we, main_from_skid;
  logic         accept;
  logic [31:0]  pc_next_sum;

  // Pack the incoming fetch into an entry, classifying it as compressed.
  always_comb begin
    in_entry            = '0;
    in_entry.rdata      = fetch_rdata_i;
    in_entry.addr       = fetch_addr_i;
    in_entry.err        = fetch_err_i;
    in_entry.err_plus2  = fetch_err_plus2_i;
    in_entry.compressed = (fetch_rdata_i[1:0] != 2'b11) && !fetch_err_i;
  end

  assign accept = fetch_valid_i && fetch_ready_q && !flush_i;

  // Next-state and entry write enables; flush overrides every other event.
  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    skid_we        = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = IFID_EMPTY;
    end else begin
      unique case (state_q)
        IFID_EMPTY: begin
          if (accept) begin
            main_we = 1'b1;
            state_d = IFID_ONE;
          end
        end
        IFID_ONE: begin
          if (accept && id_ready_i) begin
            main_we = 1'b1;
          end else if (accept) begin
            skid_we = 1'b1;
            state_d = IFID_TWO;
          end else if (id_ready_i) begin
            state_d = IFID_EMPTY;
          end
        end
        IFID_TWO: begin
          if (id_ready_i) begin
            main_we        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = IFID_ONE;
          end
        end
        default: state_d = IFID_EMPTY;
      endcase
    end
  end

  assign main_d        = main_from_skid ? skid_q : in_entry;
  assign skid_d        = in_entry;
  assign fetch_ready_d = (state_d != IFID_TWO);

  // Control flops: occupancy and the registered ready back to fetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IFID_EMPTY;
      fetch_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      fetch_ready_q <= fetch_ready_d;
    end
  end

  if (ResetAll) begin : g_data_reset
    // Entry storage, cleared on reset in this configuration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (main_we) main_q <= main_d;
        if (skid_we) skid_q <= skid_d;
      end
    end
  end else begin : g_data_noreset
    // Entry storage without reset; contents only matter while valid.
    always_ff @(posedge clk_i) begin
      if (main_we) main_q <= main_d;
      if (skid_we) skid_q <= skid_d;
    end
  end

  assign pc_next_sum = main_q.addr +
                       (main_q.compressed ? IFID_PC_INC_COMP : IFID_PC_INC_FULL);

  assign fetch_ready_o              = fetch_ready_q;
  assign instr_valid_id_o           = (state_q != IFID_EMPTY);
  assign instr_rdata_id_o           = main_q.rdata;
  assign instr_is_compressed_id_o   = main_q.compressed;
  assign pc_id_o                    = main_q.addr;
  assign instr_fetch_err_id_o       = main_q.err;
  assign instr_fetch_err_plus2_id_o = main_q.err_plus2;
  // With full reset the fall-through PC also reads zero while nothing is held.
  assign pc_next_id_o = (ResetAll && !instr_valid_id_o) ? 32'd0 : pc_next_sum;

endmodule

// File: tb/tb_ibex_if_id_skid_reg.sv
// Scoreboard bench for the IF/ID skid register: stimulus pushes expected
// instructions, a negedge monitor pops them as ID consumes each one.
module tb_ibex_if_id_skid_reg;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_err_i;
  logic        fetch_err_plus2_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        id_ready_i;
  logic        instr_valid_id_o;
  logic [31:0] instr_rdata_id_o;
  logic        instr_is_compressed_id_o;
  logic [31:0] pc_id_o;
  logic [31:0] pc_next_id_o;
  logic        instr_fetch_err_id_o;
  logic        instr_fetch_err_plus2_id_o;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] pcNext;
    logic        err;
    logic        errPlus2;
    logic        compressed;
  } expEntry_t;

  expEntry_t expQueue[$];
  expEntry_t popped;
  int checkCount = 0;
  int failCount  = 0;

  ibex_if_id_skid_reg #(.ResetAll(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i),
    .fetch_addr_i(fetch_addr_i), .fetch_err_i(fetch_err_i),
    .fetch_err_plus2_i(fetch_err_plus2_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .id_ready_i(id_ready_i),
    .instr_valid_id_o(instr_valid_id_o), .instr_rdata_id_o(instr_rdata_id_o),
    .instr_is_compressed_id_o(instr_is_compressed_id_o), .pc_id_o(pc_id_o),
    .pc_next_id_o(pc_next_id_o), .instr_fetch_err_id_o(instr_fetch_err_id_o),
    .instr_fetch_err_plus2_id_o(instr_fetch_err_plus2_id_o)
  );

  ibex_if_id_skid_reg_monitor mon (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i),
    .fetch_addr_i(fetch_addr_i), .fetch_err_i(fetch_err_i),
    .fetch_err_plus2_i(fetch_err_plus2_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .id_ready_i(id_ready_i),
    .instr_valid_id_o(instr_valid_id_o), .instr_rdata_id_o(instr_rdata_id_o),
    .instr_is_compressed_id_o(instr_is_compressed_id_o), .pc_id_o(pc_id_o),
    .pc_next_id_o(pc_next_id_o), .instr_fetch_err_id_o(instr_fetch_err_id_o),
    .instr_fetch_err_plus2_id_o(instr_fetch_err_plus2_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive one cycle of fetch/ID inputs; record the instruction if it is
  // expected to be accepted, and forget everything held on a flush.
  task automatic applyStimulus(input logic fv, input logic [31:0] rdata,
                               input logic [31:0] addr, input logic err,
                               input logic ep2, input logic flush,
                               input logic idReady, input logic expAccept,
                               input logic expComp, input logic [31:0] expPcNext);
    expEntry_t e;
    fetch_valid_i     = fv;
    fetch_rdata_i     = rdata;
    fetch_addr_i      = addr;
    fetch_err_i       = err;
    fetch_err_plus2_i = ep2;
    flush_i           = flush;
    id_ready_i        = idReady;
    if (flush) expQueue.delete();
    if (expAccept) begin
      e.rdata      = rdata;
      e.addr       = addr;
      e.pcNext     = expPcNext;
      e.err        = err;
      e.errPlus2   = ep2;
      e.compressed = expComp;
      expQueue.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleCycle(input logic idReady);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, idReady, 1'b0, 1'b0, 32'h0);
  endtask

  // Scoreboard side: every instruction ID consumes must be the next expected one.
  always @(negedge clk_i) begin
    if (rst_ni && instr_valid_id_o && id_ready_i && !flush_i) begin
      if (expQueue.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpectedOutput: got pc 0x%08h, expected no instruction",
                 pc_id_o);
      end else begin
        popped = expQueue.pop_front();
        checkOutput("outPc", pc_id_o, popped.addr);
        checkOutput("outRdata", instr_rdata_id_o, popped.rdata);
        checkOutput("outPcNext", pc_next_id_o, popped.pcNext);
        checkOutput("outComp", {31'd0, instr_is_compressed_id_o}, {31'd0, popped.compressed});
        checkOutput("outErr", {31'd0, instr_fetch_err_id_o}, {31'd0, popped.err});
        checkOutput("outErrPlus2", {31'd0, instr_fetch_err_plus2_id_o},
                    {31'd0, popped.errPlus2});
      end
    end
  end

  initial begin
    fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0; fetch_addr_i = 32'h0;
    fetch_err_i = 1'b0; fetch_err_plus2_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rstValid", {31'd0, instr_valid_id_o}, 32'd0);
    checkOutput("rstReady", {31'd0, fetch_ready_o}, 32'd1);
    checkOutput("rstPc", pc_id_o, 32'd0);
    checkOutput("rstPcNext", pc_next_id_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Basic full-width instruction.
    applyStimulus(1, 32'h00000413, 32'h80, 0, 0, 0, 0, 1, 0, 32'h84);
    checkOutput("basicValid", {31'd0, instr_valid_id_o}, 32'd1);
    checkOutput("basicComp", {31'd0, instr_is_compressed_id_o}, 32'd0);
    checkOutput("basicPcNext", pc_next_id_o, 32'h84);
    idleCycle(1);
    checkOutput("basicDrained", {31'd0, instr_valid_id_o}, 32'd0);

    // Compressed instruction.
    applyStimulus(1, 32'h00004501, 32'h100, 0, 0, 0, 0, 1, 1, 32'h102);
    checkOutput("compFlag", {31'd0, instr_is_compressed_id_o}, 32'd1);
    checkOutput("compPcNext", pc_next_id_o, 32'h102);
    idleCycle(1);

    // Stall fill into TWO, then drain in order.
    applyStimulus(1, 32'h00000013, 32'h200, 0, 0, 0, 0, 1, 0, 32'h204);
    checkOutput("fillReadyOne", {31'd0, fetch_ready_o}, 32'd1);
    applyStimulus(1, 32'h00000013, 32'h204, 0, 0, 0, 0, 1, 0, 32'h208);
    checkOutput("fillReadyTwo", {31'd0, fetch_ready_o}, 32'd0);
    checkOutput("fillPcHeld", pc_id_o, 32'h200);
    applyStimulus(1, 32'h00000013, 32'h208, 0, 0, 0, 0, 0, 0, 32'h20C);
    checkOutput("fillPcStall", pc_id_o, 32'h200);
    checkOutput("fillReadyStall", {31'd0, fetch_ready_o}, 32'd0);
    idleCycle(1);
    checkOutput("drainReady", {31'd0, fetch_ready_o}, 32'd1);
    checkOutput("drainPc", pc_id_o, 32'h204);
    idleCycle(1);
    checkOutput("drainEmpty", {31'd0, instr_valid_id_o}, 32'd0);

    // Flush in TWO with an incoming instruction that must be dropped.
    applyStimulus(1, 32'h00000013, 32'h280, 0, 0, 0, 0, 1, 0, 32'h284);
    applyStimulus(1, 32'h00000013, 32'h284, 0, 0, 0, 0, 1, 0, 32'h288);
    applyStimulus(1, 32'h00000013, 32'h300, 0, 0, 1, 0, 0, 0, 32'h304);
    checkOutput("flushValid", {31'd0, instr_valid_id_o}, 32'd0);
    checkOutput("flushReady", {31'd0, fetch_ready_o}, 32'd1);
    idleCycle(1);
    checkOutput("flushStillEmpty", {31'd0, instr_valid_id_o}, 32'd0);

    // Error with PC wrap.
    applyStimulus(1, 32'h00000001, 32'hFFFFFFFC, 1, 1, 0, 0, 1, 0, 32'h0);
    checkOutput("errFlag", {31'd0, instr_fetch_err_id_o}, 32'd1);
    checkOutput("errPlus2", {31'd0, instr_fetch_err_plus2_id_o}, 32'd1);
    checkOutput("errComp", {31'd0, instr_is_compressed_id_o}, 32'd0);
    checkOutput("errPcNext", pc_next_id_o, 32'h0);
    idleCycle(1);

    // Compressed wrap; err_plus2 stored even with err low.
    applyStimulus(1, 32'h00004501, 32'hFFFFFFFE, 0, 1, 0, 0, 1, 1, 32'h0);
    checkOutput("wrapPcNext", pc_next_id_o, 32'h0);
    checkOutput("wrapPlus2Unmasked", {31'd0, instr_fetch_err_plus2_id_o}, 32'd1);
    idleCycle(1);

    // Streaming: accept and consume in the same cycle.
    applyStimulus(1, 32'h00000013, 32'h400, 0, 0, 0, 0, 1, 0, 32'h404);
    applyStimulus(1, 32'h00004501, 32'h404, 0, 0, 0, 1, 1, 1, 32'h406);
    checkOutput("streamPc", pc_id_o, 32'h404);
    checkOutput("streamValid", {31'd0, instr_valid_id_o}, 32'd1);
    idleCycle(1);

    // id_ready while empty does nothing.
    idleCycle(1);
    checkOutput("emptyIdReady", {31'd0, instr_valid_id_o}, 32'd0);
    checkOutput("emptyReady", {31'd0, fetch_ready_o}, 32'd1);

    // Flush in ONE drops both held and incoming.
    applyStimulus(1, 32'h00000013, 32'h480, 0, 0, 0, 0, 1, 0, 32'h484);
    applyStimulus(1, 32'h00000013, 32'h484, 0, 0, 1, 0, 0, 0, 32'h488);
    checkOutput("flushOneValid", {31'd0, instr_valid_id_o}, 32'd0);

    // Asynchronous reset while in TWO.
    applyStimulus(1, 32'h00000013, 32'h500, 0, 0, 0, 0, 1, 0, 32'h504);
    applyStimulus(1, 32'h00000013, 32'h504, 0, 0, 0, 0, 1, 0, 32'h508);
    fetch_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    expQueue.delete();
    #1;
    checkOutput("asyncValid", {31'd0, instr_valid_id_o}, 32'd0);
    checkOutput("asyncReady", {31'd0, fetch_ready_o}, 32'd1);
    checkOutput("asyncPc", pc_id_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idleCycle(1);
    checkOutput("postResetValid", {31'd0, instr_valid_id_o}, 32'd0);
    checkOutput("queueDrained", expQueue.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/ibex_if_id_skid_reg.md
IBEX_IF_ID_SKID_REG -- requirements
Module: ibex_if_id_skid_reg

Interface
REQ-001 The block SHALL have parameter ResetAll, default 1'b0, meaning that when 1 all data flops are asynchronously reset, not only control flops.
REQ-002 The block SHALL have the port list below; the clock is the single clock and reset is asynchronous, active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- fetch_valid_i  in  1  prefetch buffer output valid.
- fetch_rdata_i  in  32  aligned instruction word.
- fetch_addr_i  in  32  instruction PC.
- fetch_err_i  in  1  fetch bus error.
- fetch_err_plus2_i  in  1  error lies in the upper halfword.
- fetch_ready_o  out  1  ready back to the prefetch buffer.
- flush_i  in  1  branch/kill, discards all held and incoming instructions.
- id_ready_i  in  1  ID stage consumes the current instruction.
- instr_valid_id_o  out  1  ID instruction valid.
- instr_rdata_id_o  out  32  ID instruction word.
- instr_is_compressed_id_o  out  1  rdata[1:0] != 2'b11, and no error.
- pc_id_o  out  32  ID PC.
- pc_next_id_o  out  32  fall-through PC.
- instr_fetch_err_id_o  out  1  registered fetch_err_i.
- instr_fetch_err_plus2_id_o  out  1  registered fetch_err_plus2_i.

Function
REQ-003 The block SHALL hold two entries: a main entry M, which drives all *_id_o outputs, and a skid entry S.
REQ-004 The state SHALL be one of EMPTY (M and S invalid), ONE (M valid) or TWO (M and S valid).
REQ-005 fetch_ready_o SHALL equal (state != TWO) and SHALL be driven directly from a flop, with no combinational path from id_ready_i or flush_i.
REQ-006 An accept SHALL be defined as fetch_valid_i && fetch_ready_o && !flush_i.
REQ-007 EMPTY: on accept, M <= in and the next state is ONE; otherwise the state stays EMPTY.
REQ-008 ONE: accept with id_ready_i -> M <= in, stay ONE; accept without id_ready_i -> S <= in, go to TWO; id_ready_i without accept -> EMPTY; otherwise hold.
REQ-009 TWO: id_ready_i -> M <= S, go to ONE; otherwise hold. No accept is possible in TWO.
REQ-010 flush_i SHALL have priority over all events: next state EMPTY, and any incoming instruction in that cycle SHALL be dropped.
REQ-011 instr_valid_id_o SHALL be high in ONE and TWO, and low in EMPTY.
REQ-012 Held entries SHALL not change while id_ready_i is low, except on flush.
REQ-013 The compressed flag SHALL be computed at capture as (rdata[1:0] != 2'b11) && !fetch_err_i, and stored in the entry.
REQ-014 pc_next_id_o SHALL equal pc_id_o + (compressed ? 2 : 4), computed modulo 2^32 (0xFFFFFFFE + 2 = 0x00000000).
REQ-015 Latency SHALL be exactly one cycle from accept to instr_valid_id_o.
REQ-016 The block SHALL never drop or reorder an accepted instruction, except on flush.
REQ-017 fetch_err_plus2_i SHALL be stored unchanged.
REQ-018 The ID stage SHALL ignore err_plus2 when err is low; the block SHALL NOT mask it.
REQ-019 id_ready_i while in EMPTY SHALL have no effect.

Reset
REQ-020 While rst_ni is low, the state SHALL be EMPTY, instr_valid_id_o 0 and fetch_ready_o 1.
REQ-021 With ResetAll=1, all entry fields and derived outputs SHALL reset to 0.
REQ-022 With ResetAll=0, data flops SHALL have no reset, and their values are don't-care while valid is low.
REQ-023 Reset asserted mid-operation SHALL discard both entries immediately (asynchronously).

Structure
REQ-024 The entry struct fetch_entry_t {rdata[31:0], addr[31:0], err, err_plus2, compressed} SHALL be defined in ibex_pkg.
REQ-025 The state enum if_id_state_e {IFID_EMPTY, IFID_ONE, IFID_TWO} SHALL be defined in ibex_pkg.
REQ-026 The block SHALL have no sub-module; compressed detection and the PC adder are inline.
REQ-027 A companion monitor ibex_if_id_skid_reg_monitor SHALL carry the same ports, all as inputs.

Verification
REQ-028 Basic: after reset, fetch_valid_i=1, rdata=0x00000413, addr=0x80 -> next cycle instr_valid_id_o=1, compressed=0, pc_next_id_o=0x84.
REQ-029 Compressed: rdata=0x00004501, addr=0x100 -> instr_is_compressed_id_o=1, pc_next_id_o=0x102.
REQ-030 Stall fill: id_ready_i=0, two instructions at 0x200 and 0x204 -> state TWO, fetch_ready_o=0, pc_id_o stays 0x200; then raise id_ready_i -> 0x200 then 0x204 are output in order, and fetch_ready_o=1 in the cycle after the first consume.
REQ-031 Flush in TWO: flush_i=1 with fetch_valid_i=1 at addr 0x300 -> next cycle instr_valid_id_o=0 and fetch_ready_o=1, and 0x300 is never output.
REQ-032 Error and wrap: fetch_err_i=1, fetch_err_plus2_i=1, rdata=0x00000001, addr=0xFFFFFFFC -> instr_fetch_err_id_o=1, err_plus2=1, compressed=0, pc_next_id_o=0x00000000.
REQ-033 Async reset: assert rst_ni low mid-cycle in TWO -> instr_valid_id_o=0 before the next clock edge, and fetch_ready_o=1.
